// File: rtl/dcpu_pkg.sv
// Shared decode constants and types for the data-memory access path.
// The alucode values are owned here so decode and the load/store unit agree.
package dcpu_pkg;

  localparam logic [5:0] ALU_LB  = 6'h10;
  localparam logic [5:0] ALU_LH  = 6'h11;
  localparam logic [5:0] ALU_LW  = 6'h12;
  localparam logic [5:0] ALU_LBU = 6'h13;
  localparam logic [5:0] ALU_LHU = 6'h14;
  localparam logic [5:0] ALU_SB  = 6'h18;
  localparam logic [5:0] ALU_SH  = 6'h19;
  localparam logic [5:0] ALU_SW  = 6'h1a;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } size_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  typedef struct packed {
    size_t size;
    logic  zero_ext;
  } access_t;

  function automatic access_t decode_access(input logic [5:0] alucode);
    access_t acc;
    acc.size     = SIZE_WORD;
    acc.zero_ext = 1'b0;
    case (alucode)
      ALU_LB, ALU_SB: acc.size = SIZE_BYTE;
      ALU_LBU: begin
        acc.size     = SIZE_BYTE;
        acc.zero_ext = 1'b1;
      end
      ALU_LH, ALU_SH: acc.size = SIZE_HALF;
      ALU_LHU: begin
        acc.size     = SIZE_HALF;
        acc.zero_ext = 1'b1;
      end
      default: acc.size = SIZE_WORD;
    endcase
    return acc;
  endfunction

  function automatic logic misaligned(input size_t size, input logic [1:0] offset);
    case (size)
      SIZE_WORD: return offset != 2'b00;
      SIZE_HALF: return offset[0];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: store byte-enables and data replication, plus
// load lane selection and sign/zero extension.
module lsu_lane
  import dcpu_pkg::*;
(
  input  size_t       store_size,
  input  logic [1:0]  store_offset,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  access_t     load_acc,
  input  logic [1:0]  load_offset,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
  always_comb begin
    be    = 4'hf;
    wdata = store_data;
    case (store_size)
      SIZE_BYTE: begin
        be    = 4'b0001 << store_offset;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        be    = store_offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = rdata[{load_offset, 3'b000} +: 8];
    load_half = load_offset[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (load_acc.size)
      SIZE_BYTE: load_data = {{24{load_byte[7] & ~load_acc.zero_ext}}, load_byte};
      SIZE_HALF: load_data = {{16{load_half[15] & ~load_acc.zero_ext}}, load_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: issues one handshaked data-memory access at a time,
// stalls the core while it is outstanding and returns the extended load value.
module load_store_unit
  import dcpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [5:0]        alucode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_result,
  output logic              load_valid,
  output logic              access_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  access_t          req_acc, held_acc;
  logic [1:0]       held_offset;
  logic             held_load;
  logic             timed_out;
  logic [31:0]      result_q;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata, lane_load;
  logic             in_idle, bad_req, accept, expire;

  assign req_acc = decode_access(alucode);
  assign in_idle = rst && (state == LSU_IDLE);
  assign bad_req = in_idle && ((is_load && is_store) ||
                   ((is_load || is_store) && misaligned(req_acc.size, addr[1:0])));
  assign accept  = in_idle && (is_load ^ is_store) && !bad_req;
  assign expire  = (state == LSU_WAIT) && !mem_ack && (count == CNT_LAST);

  lsu_lane u_lane (
    .store_size   (req_acc.size),
    .store_offset (addr[1:0]),
    .store_data   (store_data),
    .be           (lane_be),
    .wdata        (lane_wdata),
    .load_acc     (held_acc),
    .load_offset  (held_offset),
    .rdata        (mem_rdata),
    .load_data    (lane_load)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= LSU_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: if (accept) state_next = LSU_WAIT;
      LSU_WAIT: if (mem_ack || expire) state_next = LSU_RESP;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= '0;
      timed_out   <= 1'b0;
      result_q    <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      held_acc    <= '0;
      held_offset <= '0;
      held_load   <= 1'b0;
    end else begin
      count <= (state == LSU_WAIT) ? count + 1'b1 : '0;
      if (state == LSU_WAIT) timed_out <= expire;
      if (accept) begin
        mem_addr    <= {addr[ADDR_W-1:2], 2'b00};
        mem_we      <= is_store;
        mem_be      <= is_store ? lane_be : 4'hf;
        mem_wdata   <= is_store ? lane_wdata : '0;
        held_acc    <= req_acc;
        held_offset <= addr[1:0];
        held_load   <= is_load;
      end
      // A fault of either kind leaves no stale load value behind.
      if (bad_req || expire)
        result_q <= '0;
      else if ((state == LSU_WAIT) && mem_ack && held_load)
        result_q <= lane_load;
    end
  end

  always_comb begin
    stall        = accept || (state == LSU_WAIT);
    mem_req      = (state == LSU_WAIT);
    load_valid   = (state == LSU_RESP) && held_load && !timed_out;
    access_fault = bad_req || ((state == LSU_RESP) && timed_out);
    load_result  = bad_req ? '0 : result_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against an arithmetic model of the memory-access rules.
module tb_load_store_unit;
  import dcpu_pkg::*;

  localparam int TMO = 6;

  logic        clk, rst, is_load, is_store, mem_ack;
  logic [5:0]  alucode;
  logic [31:0] addr, store_data, mem_rdata;
  logic        stall, load_valid, access_fault, mem_req, mem_we;
  logic [31:0] load_result, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_result = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .is_load(is_load), .is_store(is_store),
    .alucode(alucode), .addr(addr), .store_data(store_data),
    .stall(stall), .load_result(load_result), .load_valid(load_valid),
    .access_fault(access_fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int size_of(input logic [5:0] code);
    if (code == ALU_LB || code == ALU_LBU || code == ALU_SB) return 1;
    if (code == ALU_LH || code == ALU_LHU || code == ALU_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] code, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz = size_of(code);
    logic [31:0] mask, raw;
    if (sz == 4) return rd;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    raw  = (rd >> (8 * (a % 4))) & mask;
    if (code != ALU_LBU && code != ALU_LHU && raw[8 * sz - 1]) raw = raw | ~mask;
    return raw;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] code, input logic [31:0] d);
    case (size_of(code))
      1:       return (d & 32'hff) * 32'h0101_0101;
      2:       return (d & 32'hffff) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [105:0] all_outputs();
    return {stall, load_result, load_valid, access_fault, mem_req, mem_we,
            mem_addr, mem_be, mem_wdata, 1'b0};
  endfunction

  // One access from the IDLE cycle through RESP; ack_at < 0 means never ack.
  task automatic do_access(input logic ld, input logic st, input logic [5:0] code,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                           input int ack_at, input string name);
    int  sz = size_of(code);
    bit  bad = (ld && st) || ((a % sz) != 0);
    bit  done = 0, timed = 0;
    int  k = 0;
    logic [3:0] exp_be;
    @(negedge clk);
    is_load = ld; is_store = st; alucode = code; addr = a; store_data = d; mem_ack = 1'b0;
    #1;
    checks++;
    if ({stall, access_fault, mem_req} !== {~bad, bad, 1'b0}) begin
      failures++;
      $display("FAIL %s_issue: stall/fault/req=%b expected=%b", name,
               {stall, access_fault, mem_req}, {~bad, bad, 1'b0});
    end
    if (bad) begin
      model_result = 32'h0;
      checks++;
      if (load_result !== 32'h0) begin
        failures++;
        $display("FAIL %s_fault_result: load_result=%h expected=0", name, load_result);
      end
      @(posedge clk);
      @(negedge clk);
      is_load = 1'b0; is_store = 1'b0;
      #1;
      checks++;
      if ({stall, access_fault, mem_req} !== 3'b000) begin
        failures++;
        $display("FAIL %s_fault_after: stall/fault/req=%b expected=000", name,
                 {stall, access_fault, mem_req});
      end
      return;
    end
    exp_be = st ? 4'(((1 << sz) - 1) << (a % 4)) : 4'hf;
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rd : $urandom;
      #1;
      checks++;
      if ({stall, mem_req, mem_we, mem_be, mem_addr} !== {2'b11, st, exp_be, a & ~32'd3}) begin
        failures++;
        $display("FAIL %s_wait%0d: stall,req,we,be,addr=%h expected=%h", name, k,
                 {stall, mem_req, mem_we, mem_be, mem_addr}, {2'b11, st, exp_be, a & ~32'd3});
      end
      if (st) begin
        checks++;
        if (mem_wdata !== model_wdata(code, d)) begin
          failures++;
          $display("FAIL %s_wdata: mem_wdata=%h expected=%h", name, mem_wdata, model_wdata(code, d));
        end
      end
      if (k == ack_at) done = 1;
      else if (k == TMO - 1) begin done = 1; timed = 1; end
      k++;
      @(posedge clk);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    if (timed) model_result = 32'h0;
    else if (ld) model_result = model_load(code, a, rd);
    checks++;
    if ({stall, mem_req, load_valid, access_fault} !== {2'b00, ld && !timed, timed}) begin
      failures++;
      $display("FAIL %s_resp: stall,req,valid,fault=%b expected=%b", name,
               {stall, mem_req, load_valid, access_fault}, {2'b00, ld && !timed, timed});
    end
    checks++;
    if (load_result !== model_result) begin
      failures++;
      $display("FAIL %s_result: load_result=%h expected=%h", name, load_result, model_result);
    end
    @(posedge clk);
  endtask

  task automatic go_idle(input string name);
    @(negedge clk);
    is_load = 1'b0; is_store = 1'b0;
    #1;
    checks++;
    if ({stall, mem_req, load_valid, access_fault, load_result} !== {4'b0000, model_result}) begin
      failures++;
      $display("FAIL %s_idle: stall,req,valid,fault,result=%h expected=%h", name,
               {stall, mem_req, load_valid, access_fault, load_result}, {4'b0000, model_result});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_ack = 1'b0;
    alucode = ALU_LW; addr = '0; store_data = '0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: outputs=%h expected=0", all_outputs());
    end
    rst = 1'b1;
    model_result = 32'h0;
  endtask

  task automatic test_store_word();
    do_access(1'b0, 1'b1, ALU_SW, 32'h100, 32'hdead_beef, 32'h0, 1, "sw");
    go_idle("sw");
  endtask

  task automatic test_load_byte();
    do_access(1'b1, 1'b0, ALU_LB, 32'h103, 32'h0, 32'h80ff_1234, 0, "lb");
    go_idle("lb");
    checks++;
    if (load_result !== 32'hffff_ff80) begin
      failures++;
      $display("FAIL lb_value: load_result=%h expected=ffffff80", load_result);
    end
    do_access(1'b1, 1'b0, ALU_LBU, 32'h103, 32'h0, 32'h80ff_1234, 0, "lbu");
    go_idle("lbu");
    checks++;
    if (load_result !== 32'h0000_0080) begin
      failures++;
      $display("FAIL lbu_value: load_result=%h expected=00000080", load_result);
    end
  endtask

  task automatic test_store_half();
    do_access(1'b0, 1'b1, ALU_SH, 32'h202, 32'h0000_abcd, 32'h0, 2, "sh");
    go_idle("sh");
  endtask

  task automatic test_faults();
    do_access(1'b1, 1'b0, ALU_LW, 32'h101, 32'h0, 32'h0, 0, "lw_misaligned");
    do_access(1'b1, 1'b1, ALU_LW, 32'h100, 32'h0, 32'h0, 0, "conflict");
    do_access(1'b0, 1'b1, ALU_SH, 32'h203, 32'h1234, 32'h0, 0, "sh_misaligned");
    go_idle("faults");
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, ALU_LW, 32'h40, 32'h0, 32'h1357_9bdf, 0, "lw_pre_timeout");
    do_access(1'b1, 1'b0, ALU_LH, 32'h10, 32'h0, 32'h0, -1, "lh_timeout");
    go_idle("timeout");
    do_access(1'b1, 1'b0, ALU_LHU, 32'h12, 32'h0, 32'hbeef_0000, TMO - 1, "lhu_last_ack");
    go_idle("last_ack");
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    is_load = 1'b1; is_store = 1'b0; alucode = ALU_LH; addr = 32'h10; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_req: mem_req=%b expected=1", mem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    is_load = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7fff_8001;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL rst_wait_clear: outputs=%h expected=0", all_outputs());
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL rst_wait_ack_ignored: outputs=%h expected=0", all_outputs());
    end
    rst = 1'b1;
    model_result = 32'h0;
    go_idle("rst_wait");
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, ALU_LW, 32'h300, 32'h0, 32'hcafe_f00d, 0, "b2b_lw");
    do_access(1'b0, 1'b1, ALU_SB, 32'h301, 32'h0000_005a, 32'h0, 0, "b2b_sb");
    do_access(1'b1, 1'b0, ALU_LHU, 32'h302, 32'h0, 32'h9abc_1234, 0, "b2b_lhu");
    go_idle("b2b");
  endtask

  task automatic test_random();
    logic [5:0] codes [8] = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
    for (int i = 0; i < 60; i++) begin
      int  sel = $urandom_range(0, 7);
      bit  st = (sel >= 5);
      bit  both = ($urandom_range(0, 9) == 0);
      int  ack_at = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TMO - 1);
      logic [31:0] a = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
      do_access(!st || both, st || both, codes[sel], a, $urandom, $urandom, ack_at, "rand");
      if ($urandom_range(0, 2) == 0) go_idle("rand");
    end
    go_idle("rand_end");
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_faults();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes the effective address from the ALU result, store data from the register file's second read port, and the load/store decode flags.
- Performs byte, halfword and word accesses to a handshaked data memory.
- Stalls the core while an access is outstanding.
- Returns the sign- or zero-extended load value for register writeback.

Parameters:
TIMEOUT_CYCLES, 16, number of cycles to wait for mem_ack before aborting; minimum 1.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, active-low, synchronous
is_load  in  1  current instruction is a load
is_store  in  1  current instruction is a store
alucode  in  6  width/sign select; LB, LH, LW, LBU, LHU, SB, SH, SW codes from the shared package
addr  in  ADDR_W  effective address (ALU result)
store_data  in  32  rs2 value
stall  out  1  core must hold the PC and all decode inputs
load_result  out  32  extended load data
load_valid  out  1  one-cycle pulse; load_result is valid
access_fault  out  1  one-cycle pulse on misalignment, load+store conflict, or timeout
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address, addr[1:0] forced to 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated write data
mem_rdata  in  32  read data; valid when mem_ack=1
mem_ack  in  1  completes the current request

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, timeout counter=0.
  - All outputs are 0: stall, load_valid, access_fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_result.
  - Reset has priority over everything, including mid-access in WAIT. mem_req drops at that edge; a later mem_ack is ignored.
- Alignment rule:
  - LW/SW: misaligned if addr[1:0]≠0.
  - LH/LHU/SH: misaligned if addr[0]≠0.
  - Bytes: never misaligned.
- IDLE:
  - If is_load^is_store and the access is aligned: stall=1 combinationally in the same cycle. Register mem_addr, mem_we, mem_be, mem_wdata; next state WAIT.
  - If misaligned, or is_load&is_store: access_fault=1 for one cycle, stall=0, no mem_req, load_result=0; stay in IDLE.
  - If neither flag is set: nothing happens.
- WAIT:
  - mem_req=1 and stall=1; the counter increments each cycle.
  - mem_ack is sampled only here, so an ack in the first WAIT cycle is legal.
  - On ack: capture the extended mem_rdata into load_result (loads only); next state RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: next state RESP with the fault flag set.
- RESP (exactly one cycle):
  - mem_req=0 and stall=0.
  - load_valid=1 for a successful load; access_fault=1 if timed out.
  - is_load/is_store are ignored (they still belong to the retiring instruction). Next state IDLE; counter cleared.
- Store lanes:
  - SB: be=1<<addr[1:0]; wdata={4{store_data[7:0]}}.
  - SH: be=0011 if addr[1]=0, else 1100; wdata={2{store_data[15:0]}}.
  - SW: be=1111; wdata=store_data.
  - Loads drive be=1111, mem_we=0.
- Load extraction: select the lane by addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- load_result holds its value until the next successful load or reset. It is cleared to 0 on a fault.
- Throughput: best case, one access per 3 cycles (IDLE, WAIT, RESP).

Decomposition:
- Package dcpu_pkg:
  - alucode localparams for LB/LH/LW/LBU/LHU/SB/SH/SW, shared with decode.
  - LSU state enum (IDLE, WAIT, RESP).
  - Width-select typedef.
- Sub-module lsu_lane: purely combinational store lane replication/byte-enable generation and load extraction/extension. The FSM and timeout counter stay in load_store_unit.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, ack after 2 WAIT cycles -> mem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; stall high for 3 cycles, low in RESP.
- LB addr=0x103, mem_rdata=0x80FF_1234, ack in first WAIT cycle -> load_result=0xFFFFFF80, load_valid pulse 1 cycle; LBU at the same address -> 0x00000080.
- SH addr=0x202, data=0x0000ABCD -> be=1100, wdata=0xABCDABCD, mem_addr=0x200.
- LW addr=0x101 -> access_fault pulse, mem_req never asserted, stall=0; then is_load=is_store=1 -> access_fault, no request.
- LH addr=0x10, mem_ack held 0 -> mem_req high for exactly TIMEOUT_CYCLES cycles, then access_fault pulse, load_valid=0, return to IDLE.
- rst=0 asserted in the 2nd WAIT cycle, with ack arriving the next cycle -> all outputs 0 after the edge, ack ignored, no load_valid.
